// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch controller: FSM encoding, the NOP word
// and the sequential PC step.
package fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_BOOT     = 2'd0,
      ST_RUN      = 2'd1,
      ST_HOLD     = 2'd2,
      ST_REDIRECT = 2'd3
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;
   localparam int unsigned PC_INCR     = 4;

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
      return (en && (v != '1)) ? v + 32'd1 : v;
   endfunction

endpackage

// File: rtl/fetch_ctrl_if_id_reg.sv
// IF/ID pipeline register: load a fetched word, hold it, or squash it to a NOP.
module fetch_ctrl_if_id_reg
   import fetch_ctrl_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(NOP_INSTR_C)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  load_i,
   input  logic                  squash_i,
   input  logic [DATA_WIDTH-1:0] pc_i,
   input  logic [DATA_WIDTH-1:0] instr_i,
   output logic [DATA_WIDTH-1:0] pc_o,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic                  valid_o
);

   logic [DATA_WIDTH-1:0] pc_q, instr_q;
   logic                  valid_q;

   // Squash keeps the PC so a later debug view still shows where the slot came from.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc_q    <= '0;
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
      end else if (squash_i) begin
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
      end else if (load_i) begin
         pc_q    <= pc_i;
         instr_q <= instr_i;
         valid_q <= 1'b1;
      end
   end

   assign pc_o    = pc_q;
   assign instr_o = instr_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch PC, address mux and stall/flush FSM feeding the IF/ID register.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] PC_RESET   = '0,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(NOP_INSTR_C)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] pc_target,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic [DATA_WIDTH-1:0] if_id_pc,
   output logic [DATA_WIDTH-1:0] if_id_instr,
   output logic                  if_id_valid,
   output logic                  id_ex_bubble,
   output logic [1:0]            state
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]           stall_cycles,
   output logic [31:0]           flush_count,
   output logic [31:0]           fetch_count
`endif
);

   fetch_state_e          state_q;
   logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic                  booting, flush_eff, load;

   assign booting   = (state_q == ST_BOOT);
   assign flush_eff = flush & ~booting;
   assign load      = ~booting & ~flush & ~stall;

   // A stalled or booting fetch re-presents the same address so its word returns again.
   always_comb begin
      if (flush_eff)
         fetch_pc_d = pc_target;
      else if (booting || stall)
         fetch_pc_d = fetch_pc_q;
      else
         fetch_pc_d = fetch_pc_q + DATA_WIDTH'(PC_INCR);
   end

   assign imem_addr    = fetch_pc_d;
   assign id_ex_bubble = (stall | flush) & ~booting;
   assign state        = state_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         fetch_pc_q <= PC_RESET;
      else
         fetch_pc_q <= fetch_pc_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_BOOT;
      end else begin
         case (state_q)
            ST_BOOT: state_q <= ST_RUN;
            default: begin
               if (flush)
                  state_q <= ST_REDIRECT;
               else if (stall)
                  state_q <= ST_HOLD;
               else
                  state_q <= ST_RUN;
            end
         endcase
      end
   end

   fetch_ctrl_if_id_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .NOP_INSTR  (NOP_INSTR)
   ) u_if_id_reg (
      .clk_i    (clk),
      .rst_i    (reset),
      .load_i   (load),
      .squash_i (flush_eff),
      .pc_i     (fetch_pc_q),
      .instr_i  (imem_rdata),
      .pc_o     (if_id_pc),
      .instr_o  (if_id_instr),
      .valid_o  (if_id_valid)
   );

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt_q, flush_cnt_q, fetch_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         fetch_cnt_q <= '0;
      end else begin
         stall_cnt_q <= sat_inc(stall_cnt_q, stall & ~flush & ~booting);
         flush_cnt_q <= sat_inc(flush_cnt_q, flush_eff);
         fetch_cnt_q <= sat_inc(fetch_cnt_q, load);
      end
   end

   assign stall_cycles = stall_cnt_q;
   assign flush_count  = flush_cnt_q;
   assign fetch_count  = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed hazard scenarios plus randomized stall/flush
// traffic against a fetch-stream reference model.
module tb_fetch_ctrl;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] pc_target = '0;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic [31:0] if_id_pc, if_id_instr;
   logic        if_id_valid, id_ex_bubble;
   logic [1:0]  state;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cycles, flush_count, fetch_count;
`endif

   int checks = 0;
   int errors = 0;

   fetch_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .flush        (flush),
      .pc_target    (pc_target),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .if_id_pc     (if_id_pc),
      .if_id_instr  (if_id_instr),
      .if_id_valid  (if_id_valid),
      .id_ex_bubble (id_ex_bubble),
      .state        (state)
`ifdef FETCH_PERF_CNT_EN
      ,
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count),
      .fetch_count  (fetch_count)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous-read memory: either address-as-data or a scrambled word.
   logic mem_scramble = 1'b0;
   function automatic logic [31:0] memf(input logic [31:0] a);
      return mem_scramble ? ((a * 32'h9E37_79B1) ^ 32'h1234_5678) : a;
   endfunction
   always @(posedge clk) imem_rdata <= memf(imem_addr);

   // Reference model: where the fetch stream stands and what IF/ID should hold.
   bit          m_boot;
   logic [1:0]  m_state;
   logic [31:0] m_fpc, e_addr, e_pc, e_instr;
   logic        e_bub, e_valid, cur_s, cur_f;
   int unsigned m_stc, m_flc, m_fec;

   task automatic model_reset();
      m_boot = 1; m_state = 2'd0; m_fpc = 32'h0;
      e_pc = 32'h0; e_instr = NOP; e_valid = 1'b0;
      m_stc = 0; m_flc = 0; m_fec = 0;
   endtask

   task automatic drive(input logic s, input logic f, input logic [31:0] tgt);
      @(negedge clk);
      stall = s; flush = f; pc_target = tgt; cur_s = s; cur_f = f;
      #1;
      if (f && !m_boot)     e_addr = tgt;
      else if (m_boot || s) e_addr = m_fpc;
      else                  e_addr = m_fpc + 32'd4;
      e_bub = (s || f) && !m_boot;
   endtask

   task automatic tick();
      @(posedge clk);
      if (!m_boot) begin
         if (cur_f) begin
            e_instr = NOP; e_valid = 1'b0; m_flc++; m_state = 2'd3;
         end else if (cur_s) begin
            m_stc++; m_state = 2'd2;
         end else begin
            e_pc = m_fpc; e_instr = memf(m_fpc); e_valid = 1'b1; m_fec++; m_state = 2'd1;
         end
      end else begin
         m_state = 2'd1;
      end
      m_boot = 0;
      m_fpc = e_addr;
      #1;
   endtask

   task automatic do_reset(input logic scr);
      @(negedge clk);
      reset = 1'b1; stall = 1'b0; flush = 1'b0; mem_scramble = scr;
      model_reset();
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1; stall = 1'b0; flush = 1'b0; mem_scramble = 1'b0;
      model_reset();
      #2;
      checks++;
      if ({if_id_pc, if_id_instr, if_id_valid} !== {32'h0, NOP, 1'b0}) begin
         errors++; $display("FAIL reset_ifid got %h/%h/%b exp 0/%h/0", if_id_pc, if_id_instr, if_id_valid, NOP);
      end
      checks++;
      if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
      checks++;
      if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
      checks++;
      if (id_ex_bubble !== 1'b0) begin errors++; $display("FAIL reset_bubble got %b exp 0", id_ex_bubble); end
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 32'h0);
         checks++;
         if (imem_addr !== 32'(4 * i) || imem_addr !== e_addr) begin
            errors++; $display("FAIL seq_addr%0d got %h exp %h", i, imem_addr, 32'(4 * i));
         end
         tick();
         checks++;
         if ({if_id_pc, if_id_instr, if_id_valid} !== {e_pc, e_instr, e_valid} ||
             if_id_valid !== (i >= 1) || (i >= 1 && if_id_pc !== 32'(4 * (i - 1)))) begin
            errors++; $display("FAIL seq_ifid%0d got %h/%h/%b exp %h/%h/%b",
                               i, if_id_pc, if_id_instr, if_id_valid, e_pc, e_instr, e_valid);
         end
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 32'h0);
         checks++;
         if (imem_addr !== 32'hC || id_ex_bubble !== 1'b1) begin
            errors++; $display("FAIL stall_addr%0d got %h/%b exp 0000000c/1", i, imem_addr, id_ex_bubble);
         end
         tick();
         checks++;
         if (if_id_pc !== 32'h8 || if_id_instr !== 32'h8 || if_id_valid !== 1'b1) begin
            errors++; $display("FAIL stall_hold%0d got pc %h instr %h exp 8", i, if_id_pc, if_id_instr);
         end
      end
      drive(1'b0, 1'b0, 32'h0);
      checks++;
      if (imem_addr !== 32'h10 || id_ex_bubble !== 1'b0) begin
         errors++; $display("FAIL stall_rel_addr got %h/%b exp 00000010/0", imem_addr, id_ex_bubble);
      end
      tick();
      checks++;
      if (if_id_pc !== 32'hC || if_id_instr !== 32'hC || if_id_valid !== 1'b1) begin
         errors++; $display("FAIL stall_release got pc %h instr %h exp c", if_id_pc, if_id_instr);
      end
   endtask

   task automatic test_flush();
      drive(1'b0, 1'b0, 32'h0);
      tick();
      checks++;
      if (if_id_pc !== 32'h10) begin errors++; $display("FAIL flush_pre got pc %h exp 10", if_id_pc); end
      drive(1'b0, 1'b1, 32'h100);
      checks++;
      if (imem_addr !== 32'h100 || id_ex_bubble !== 1'b1) begin
         errors++; $display("FAIL flush_addr got %h/%b exp 00000100/1", imem_addr, id_ex_bubble);
      end
      tick();
      checks++;
      if (if_id_instr !== NOP || if_id_valid !== 1'b0 || state !== 2'd3) begin
         errors++; $display("FAIL flush_squash got %h/%b st %0d exp %h/0 st 3", if_id_instr, if_id_valid, state, NOP);
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b0, 32'h0);
         tick();
         checks++;
         if (if_id_pc !== 32'(32'h100 + 4 * i) || if_id_instr !== if_id_pc || if_id_valid !== 1'b1) begin
            errors++; $display("FAIL flush_target%0d got pc %h instr %h exp %h", i, if_id_pc, if_id_instr, 32'(32'h100 + 4 * i));
         end
      end
   endtask

   task automatic test_stall_flush();
      drive(1'b1, 1'b1, 32'h40);
      checks++;
      if (imem_addr !== 32'h40 || id_ex_bubble !== 1'b1) begin
         errors++; $display("FAIL sf_addr got %h/%b exp 00000040/1", imem_addr, id_ex_bubble);
      end
      tick();
      checks++;
      if (state !== 2'd3 || if_id_valid !== 1'b0 || if_id_instr !== NOP) begin
         errors++; $display("FAIL sf_squash got st %0d %h/%b exp st 3 %h/0", state, if_id_instr, if_id_valid, NOP);
      end
      drive(1'b0, 1'b0, 32'h0);
      tick();
      checks++;
      if (if_id_pc !== 32'h40 || if_id_valid !== 1'b1) begin
         errors++; $display("FAIL sf_target got pc %h/%b exp 40/1", if_id_pc, if_id_valid);
      end
   endtask

   task automatic test_boot_flush();
      do_reset(1'b0);
      drive(1'b0, 1'b1, 32'h80);
      checks++;
      if (imem_addr !== 32'h0 || id_ex_bubble !== 1'b0 || state !== 2'd0) begin
         errors++; $display("FAIL boot_flush_addr got %h/%b st %0d exp 0/0 st 0", imem_addr, id_ex_bubble, state);
      end
      tick();
      checks++;
      if (state !== 2'd1 || if_id_valid !== 1'b0) begin
         errors++; $display("FAIL boot_flush_state got st %0d v %b exp st 1 v 0", state, if_id_valid);
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b0, 32'h0);
         checks++;
         if (imem_addr !== 32'(4 * (i + 1))) begin
            errors++; $display("FAIL boot_flush_seq%0d got %h exp %h", i, imem_addr, 32'(4 * (i + 1)));
         end
         tick();
         checks++;
         if (if_id_pc !== 32'(4 * i) || if_id_valid !== 1'b1) begin
            errors++; $display("FAIL boot_flush_ifid%0d got %h exp %h", i, if_id_pc, 32'(4 * i));
         end
      end
   endtask

   task automatic test_reset_in_hold();
      int n;
      do_reset(1'b0);
      n = 0;
      while (!(e_valid && e_pc == 32'h20) && n < 20) begin
         drive(1'b0, 1'b0, 32'h0);
         tick();
         n++;
      end
      checks++;
      if (if_id_pc !== 32'h20 || n >= 20) begin
         errors++; $display("FAIL hold_reach got pc %h exp 00000020", if_id_pc);
      end
      drive(1'b1, 1'b0, 32'h0);
      tick();
      drive(1'b1, 1'b0, 32'h0);
      #1 reset = 1'b1;
      model_reset();
      #1;
      checks++;
      if ({if_id_pc, if_id_instr, if_id_valid, state, imem_addr, id_ex_bubble} !== {32'h0, NOP, 1'b0, 2'd0, 32'h0, 1'b0}) begin
         errors++; $display("FAIL hold_async_reset got pc %h instr %h v %b st %0d addr %h bub %b",
                            if_id_pc, if_id_instr, if_id_valid, state, imem_addr, id_ex_bubble);
      end
      @(posedge clk);
      #1 reset = 1'b0; stall = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 32'h0);
         checks++;
         if (imem_addr !== 32'(4 * i)) begin
            errors++; $display("FAIL hold_restart%0d got %h exp %h", i, imem_addr, 32'(4 * i));
         end
         tick();
      end
      checks++;
      if (if_id_pc !== 32'h4 || if_id_valid !== 1'b1) begin
         errors++; $display("FAIL hold_restart_ifid got %h exp 4", if_id_pc);
      end
   endtask

`ifdef FETCH_PERF_CNT_EN
   task automatic test_perf();
      logic [3:0] sv, fv;
      sv = 4'b0011; fv = 4'b0100;
      do_reset(1'b0);
      for (int i = 0; i < 3; i++) begin drive(1'b0, 1'b0, 32'h0); tick(); end
      for (int i = 0; i < 4; i++) begin drive(sv[i], fv[i], 32'h200); tick(); end
      checks++;
      if (stall_cycles !== 32'd2 || flush_count !== 32'd1) begin
         errors++; $display("FAIL perf_cnt got stall %0d flush %0d exp 2 1", stall_cycles, flush_count);
      end
      checks++;
      if (fetch_count !== 32'd3) begin
         errors++; $display("FAIL perf_fetch got %0d exp 3", fetch_count);
      end
   endtask
`endif

   task automatic test_random();
      logic s, f;
      logic [31:0] tgt;
      do_reset(1'b1);
      for (int i = 0; i < 400; i++) begin
         s = ($urandom % 4) == 0;
         f = ($urandom % 6) == 0;
         tgt = (($urandom % 5) == 0) ? 32'hFFFF_FFF8 : $urandom;
         drive(s, f, tgt);
         checks++;
         if (imem_addr !== e_addr || id_ex_bubble !== e_bub || state !== m_state) begin
            errors++; $display("FAIL rand_comb%0d got %h/%b/%0d exp %h/%b/%0d",
                               i, imem_addr, id_ex_bubble, state, e_addr, e_bub, m_state);
         end
         tick();
         checks++;
         if ({if_id_pc, if_id_instr, if_id_valid} !== {e_pc, e_instr, e_valid}) begin
            errors++; $display("FAIL rand_ifid%0d got %h/%h/%b exp %h/%h/%b",
                               i, if_id_pc, if_id_instr, if_id_valid, e_pc, e_instr, e_valid);
         end
      end
`ifdef FETCH_PERF_CNT_EN
      checks++;
      if (stall_cycles !== m_stc || flush_count !== m_flc || fetch_count !== m_fec) begin
         errors++; $display("FAIL rand_perf got %0d/%0d/%0d exp %0d/%0d/%0d",
                            stall_cycles, flush_count, fetch_count, m_stc, m_flc, m_fec);
      end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_flush();
      test_stall_flush();
      test_boot_flush();
      test_reset_in_hold();
`ifdef FETCH_PERF_CNT_EN
      test_perf();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
